pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
- Programmable serial pattern-scan controller.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first.
- Runs each bit through a programmable PLEN-bit pattern matcher, with overlapping or non-overlapping detection.
- Counts matches per frame, signals frame completion, and owns all sequencing and configuration of the bit-level detector.

Parameters:
- DW, 8: input word width in bits.
- PLEN, 3: pattern length in bits, at least 2.
- CNT_W, 4: match counter width; the counter saturates.
- PAT_RST, 3'b101: pattern loaded at reset, PLEN bits wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PLEN  pattern to detect; the MSB is compared against the oldest bit.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DW  word to scan, MSB first.
- in_last  in  1  this word closes the frame.
- match_pulse  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches in the current or just-finished frame.
- done  out  1  one-cycle pulse at frame end.
- busy  out  1  a frame is open, or the block is shifting.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
  - Reset values: state=IDLE, pattern=PAT_RST, overlap=1, history=0, fill=0, frame_open=0, match_pulse=0, match_cnt=0, done=0, busy=0.
- States: IDLE, SHIFT, DONE.
- in_ready:
  - in_ready = (state==IDLE), combinational.
  - It is therefore 1 during reset.
- IDLE:
  - Handshake: a word is accepted when in_valid && in_ready.
  - On accept, load the shift register with in_data, latch in_last, set bit counter=DW-1, and go to SHIFT.
  - If frame_open==0 at accept (first word of a frame): clear history, fill and match_cnt, then set frame_open=1.
- SHIFT, each edge consumes one bit b (the current MSB):
  - history <= {history[PLEN-2:0], b}.
  - fill <= min(fill+1, PLEN).
- Match rule:
  - A match occurs when (fill+1 >= PLEN) and {history[PLEN-2:0], b} == pattern.
  - On a match, at the same edge: match_pulse<=1 and match_cnt<=match_cnt+1, saturating at 2^CNT_W-1.
  - If a match occurs and overlap==0, fill<=0 instead.
  - Otherwise match_pulse<=0.
- End of word (edge consuming bit 0):
  - If the latched last==1: go to DONE, set done<=1 and frame_open<=0.
  - Otherwise go to IDLE. History and fill persist, so matches span word boundaries.
- DONE:
  - Lasts one cycle; done<=0 on exit, then go to IDLE.
  - match_cnt holds until the next frame's first accept.
- Latency and throughput:
  - Accept at edge T; bits consumed at edges T+1..T+DW.
  - done is high in the cycle after edge T+DW.
  - Throughput is DW+1 cycles per word.
- Configuration:
  - cfg_we is honoured only when state==IDLE and frame_open==0.
  - Otherwise it is silently ignored; no error flag.
- busy = frame_open || state!=IDLE.
- Simultaneous events:
  - cfg_we together with an accept of a first word: the new config applies to that frame.
- Reset mid-frame: returns immediately to reset values; any partial count is discarded.

Decomposition:
- Shared package (pattern_scan_pkg):
  - state enum: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - default PAT_RST constant.
- One natural sub-module, pattern_match_core:
  - Holds the history, fill and overlap handling.
  - Inputs: bit_valid, bit, clear, pattern, overlap.
  - Output: match, combinational.
  - The controller owns the FSM, handshake, counter and configuration.

Test Plan:
- Reset test: assert rst mid-SHIFT.
  - Required: all outputs 0 asynchronously and in_ready=1.
  - After release, word 8'hA5 with last is accepted normally, and the count restarts from 0.
- Overlap on, pattern 101, single word 8'b1010_1010 with last=1.
  - Required: match_pulse after bits 3, 5 and 7, so match_cnt=3.
  - done at edge T+8 plus one cycle.
- Overlap off (cfg written in IDLE), same word.
  - Required: matches at bits 3 and 7 only, so match_cnt=2.
- Frame across words: 8'b0000_0010 (last=0), then 8'b1000_0000 (last=1).
  - Required: one match, on the first bit of the second word; match_cnt=1 and a single done.
- Same two words, each sent with last=1.
  - Required: history is cleared between frames, so both frames report match_cnt=0.
- Saturation and ignored config: CNT_W=2, pattern 111, word 8'hFF.
  - Required: 6 match pulses, with match_cnt=3 (saturated).
  - cfg_we with pattern 000 during SHIFT must not change the detected pattern.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the pattern scan controller and its bit-level matcher.
package pattern_scan_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [2:0] PAT_RST_DEF = 3'b101;
endpackage

// File: rtl/pattern_match_core.sv
// Bit-level PLEN-bit matcher: keeps the recent-bit history and the count of valid history bits.
module pattern_match_core #(
  parameter int PLEN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_valid,
  input  logic            bit_data,
  input  logic            clear,
  input  logic [PLEN-1:0] pattern,
  input  logic            overlap,
  output logic            match
);
  localparam int FW = $clog2(PLEN + 1);

  logic [PLEN-2:0] hist;
  logic [FW-1:0]   fill;
  logic [PLEN-1:0] nxt;

  assign nxt   = {hist, bit_data};
  assign match = bit_valid && (fill >= FW'(PLEN - 1)) && (nxt == pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= nxt[PLEN-2:0];
      // Non-overlapping mode: a match consumes its bits, so a fresh window must fill again.
      if (match && !overlap)
        fill <= '0;
      else if (fill != FW'(PLEN))
        fill <= fill + 1'b1;
    end
  end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-accepting serial pattern scanner: handshake, MSB-first shifter, per-frame match counting.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int              DW      = 8,
  parameter int              PLEN    = 3,
  parameter int              CNT_W   = 4,
  parameter logic [PLEN-1:0] PAT_RST = PAT_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PLEN-1:0]  cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             busy
);
  localparam int              BW      = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  logic [DW-1:0]   sreg;
  logic [BW-1:0]   bcnt;
  logic            last_q;
  logic            frame_open;
  logic [PLEN-1:0] pattern_q;
  logic            overlap_q;
  logic            match;
  logic            accept;
  logic            first;
  logic            bit_valid;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign first     = accept && !frame_open;
  assign bit_valid = (state == SHIFT);
  assign busy      = frame_open || (state != IDLE);

  pattern_match_core #(.PLEN(PLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_data  (sreg[DW-1]),
    .clear     (first),
    .pattern   (pattern_q),
    .overlap   (overlap_q),
    .match     (match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      bcnt        <= '0;
      last_q      <= 1'b0;
      frame_open  <= 1'b0;
      pattern_q   <= PAT_RST;
      overlap_q   <= 1'b1;
      match_pulse <= 1'b0;
      match_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      match_pulse <= 1'b0;
      // Config only lands between frames; a write alongside a first word applies to that frame.
      if (cfg_we && (state == IDLE) && !frame_open) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            sreg   <= in_data;
            last_q <= in_last;
            bcnt   <= BW'(DW - 1);
            state  <= SHIFT;
            if (!frame_open) begin
              match_cnt  <= '0;
              frame_open <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sreg <= sreg << 1;
          bcnt <= bcnt - 1'b1;
          if (match) begin
            match_pulse <= 1'b1;
            if (match_cnt != CNT_MAX)
              match_cnt <= match_cnt + 1'b1;
          end
          if (bcnt == '0) begin
            if (last_q) begin
              state      <= DONE;
              done       <= 1'b1;
              frame_open <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed table, reset/config corner sequences, random frames vs a window model.
module tb_pattern_scan_ctrl;
  localparam int DW = 8;
  localparam int PLEN = 3;

  logic clk = 1'b0;
  logic rst;
  logic cfg_we;
  logic [PLEN-1:0] cfg_pattern;
  logic cfg_overlap;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic in_last;

  logic in_ready_a, match_pulse_a, done_a, busy_a;
  logic [3:0] match_cnt_a;
  logic in_ready_b, match_pulse_b, done_b, busy_b;
  logic [1:0] match_cnt_b;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.DW(DW), .PLEN(PLEN), .CNT_W(4), .PAT_RST(3'b101)) dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .match_pulse(match_pulse_a), .match_cnt(match_cnt_a), .done(done_a), .busy(busy_a)
  );

  pattern_scan_ctrl #(.DW(DW), .PLEN(PLEN), .CNT_W(2), .PAT_RST(3'b101)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .match_pulse(match_pulse_b), .match_cnt(match_cnt_b), .done(done_b), .busy(busy_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the frame's bit stream, and the end index of the last counted match.
  logic [PLEN-1:0] m_pat;
  bit m_ovl;
  bit m_open;
  int m_cnt;
  int m_last_end;
  bit mq[$];

  typedef struct {
    bit do_cfg;
    logic [2:0] pat;
    bit ovl;
    logic [7:0] data;
    bit last;
    bit inject;
    int exp_a;
    int exp_b;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic bit model_bit(input bit b);
    int i;
    mq.push_back(b);
    i = mq.size() - 1;
    if (i < PLEN - 1) return 1'b0;
    for (int j = 0; j < PLEN; j++)
      if (mq[i-PLEN+1+j] != m_pat[PLEN-1-j]) return 1'b0;
    if (!m_ovl && (i - PLEN + 1) <= m_last_end) return 1'b0;
    m_last_end = i;
    m_cnt++;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pat = 3'b101;
    m_ovl = 1'b1;
    m_open = 1'b0;
    m_cnt = 0;
    m_last_end = -1;
    mq.delete();
  endtask

  task automatic cfg_idle(input logic [PLEN-1:0] p, input bit o);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_overlap = o;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (!m_open) begin
      m_pat = p;
      m_ovl = o;
    end
  endtask

  task automatic run_word(input logic [DW-1:0] d, input bit last, input bit cfg_now,
                          input logic [PLEN-1:0] p, input bit o, input bit inject);
    int n;
    bit exp;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    if (cfg_now) begin
      cfg_we = 1'b1;
      cfg_pattern = p;
      cfg_overlap = o;
    end
    n = 0;
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    if (cfg_now && !m_open) begin
      m_pat = p;
      m_ovl = o;
    end
    if (!m_open) begin
      mq.delete();
      m_cnt = 0;
      m_last_end = -1;
      m_open = 1'b1;
    end
    chk("busy_shift", busy_a, 1);
    for (int k = 0; k < DW; k++) begin
      if (inject && k == 2) begin
        cfg_we = 1'b1;
        cfg_pattern = '0;
        cfg_overlap = 1'b0;
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      exp = model_bit(d[DW-1-k]);
      chk("pulse_a", match_pulse_a, exp);
      chk("pulse_b", match_pulse_b, exp);
    end
    if (last) m_open = 1'b0;
    chk("done_edge", done_a, last);
    chk("cnt_a", match_cnt_a, sat(m_cnt, 15));
    chk("cnt_b", match_cnt_b, sat(m_cnt, 3));
    if (last) begin
      @(posedge clk);
      #1;
      chk("done_clear", done_a, 0);
      chk("busy_after", busy_a, 0);
      chk("ready_after", in_ready_a, 1);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'b101, 1'b1, 8'hAA, 1'b1, 1'b0, 3, 3};
    tbl[1] = '{1'b1, 3'b101, 1'b0, 8'hAA, 1'b1, 1'b0, 2, 2};
    tbl[2] = '{1'b1, 3'b101, 1'b1, 8'h02, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{1'b1, 3'b000, 1'b0, 8'h80, 1'b1, 1'b0, 1, 1};
    tbl[4] = '{1'b0, 3'b101, 1'b1, 8'h02, 1'b1, 1'b0, 0, 0};
    tbl[5] = '{1'b0, 3'b101, 1'b1, 8'h80, 1'b1, 1'b0, 0, 0};
    tbl[6] = '{1'b1, 3'b111, 1'b1, 8'hFF, 1'b1, 1'b1, 6, 3};

    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_pattern = '0;
    cfg_overlap = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    model_reset();
    #1;
    chk("rst_pulse", match_pulse_a, 0);
    chk("rst_cnt", match_cnt_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", in_ready_a, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].do_cfg) cfg_idle(tbl[t].pat, tbl[t].ovl);
      run_word(tbl[t].data, tbl[t].last, 1'b0, '0, 1'b0, tbl[t].inject);
      chk($sformatf("tbl%0d_cnt_a", t), match_cnt_a, tbl[t].exp_a);
      chk($sformatf("tbl%0d_cnt_b", t), match_cnt_b, tbl[t].exp_b);
    end

    // Reset during SHIFT: everything clears at once, pattern/overlap return to defaults.
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pulse", match_pulse_a, 0);
    chk("mid_rst_cnt", match_cnt_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_ready", in_ready_a, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_word(8'hA5, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_cnt", match_cnt_a, 2);

    // Config in the same cycle as the first word of a frame.
    run_word(8'b0000_0111, 1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
    chk("cfg_with_accept", match_cnt_a, 1);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_idle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_word(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b0, '0, 1'b0, 1'b0);
    end
    if (m_open) run_word(8'($urandom_range(0, 255)), 1'b1, 1'b0, '0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
